// File: rtl/pipe_ctrl_pkg.sv
// Shared types and widths for the pipeline sequencer.
// Provides register/data bus widths, the FSM state encoding and the
// bundled control-vector type driven onto the pipeline registers.
package pipe_ctrl_pkg;

    localparam int unsigned REG_ADDR_W = 5;   // RegAddrBus
    localparam int unsigned REG_DATA_W = 32;  // RegDataBus
    localparam int unsigned STATE_W    = 2;   // PipeCtrlStateBus
    localparam int unsigned CNT_W      = 32;
    localparam int unsigned WAIT_W     = 8;   // holds MEM_TIMEOUT-1 up to 254

    typedef enum logic [STATE_W-1:0] {
        PC_RUN      = 2'd0,
        PC_MEM_WAIT = 2'd1,
        PC_ERROR    = 2'd2
    } pipe_ctrl_state_e;

    // Stall/flush/redirect controls, one bit per pipeline register action.
    typedef struct packed {
        logic pc_stall;
        logic if_id_stall;
        logic id_ex_stall;
        logic ex_mem_stall;
        logic if_id_flush;
        logic id_ex_flush;
        logic mem_wb_flush;
        logic pc_redirect;
    } pipe_ctrl_s;

    // Freeze the whole front of the pipe and bubble MEM/WB.
    function automatic pipe_ctrl_s ctrl_hold();
        pipe_ctrl_s c;
        c              = '0;
        c.pc_stall     = 1'b1;
        c.if_id_stall  = 1'b1;
        c.id_ex_stall  = 1'b1;
        c.ex_mem_stall = 1'b1;
        c.mem_wb_flush = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/pipe_hazard_detect.sv
// Load-use hazard comparator (purely combinational).
// Ports: ID source addresses/use flags, EX load flag and destination;
// load_use_c is high when the ID instruction needs the EX load result.
module pipe_hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    input  logic                  rs1_used,
    input  logic                  rs2_used,
    input  logic                  ex_rmem_en,
    input  logic [REG_ADDR_W-1:0] ex_wreg_addr,
    output logic                  load_use_c
);

    // x0 is hardwired zero, so a load targeting it never creates a dependency.
    assign load_use_c = ex_rmem_en && (ex_wreg_addr != '0) &&
                        ((rs1_used && (rs1_addr == ex_wreg_addr)) ||
                         (rs2_used && (rs2_addr == ex_wreg_addr)));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: stall/flush/redirect generation for load-use
// hazards, taken branches and multi-cycle memory accesses, plus a memory
// timeout detector and stall/redirect performance counters.
// Ports: clk, rst_n; ID/EX hazard inputs; branch taken/target; MEM
// req/ack; stall, flush and redirect controls (combinational); mem_err_o,
// stall_cnt_o, redirect_cnt_o (registered).
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr_i,
    input  logic                  id_rs1_used_i,
    input  logic                  id_rs2_used_i,
    input  logic                  ex_rmem_en_i,
    input  logic [REG_ADDR_W-1:0] ex_wreg_addr_i,
    input  logic                  ex_branch_taken_i,
    input  logic [REG_DATA_W-1:0] ex_branch_target_i,
    input  logic                  mem_req_i,
    input  logic                  mem_ack_i,
    output logic                  pc_stall_o,
    output logic                  if_id_stall_o,
    output logic                  id_ex_stall_o,
    output logic                  ex_mem_stall_o,
    output logic                  if_id_flush_o,
    output logic                  id_ex_flush_o,
    output logic                  mem_wb_flush_o,
    output logic                  pc_redirect_o,
    output logic [REG_DATA_W-1:0] pc_redirect_addr_o,
    output logic                  mem_err_o,
    output logic [CNT_W-1:0]      stall_cnt_o,
    output logic [CNT_W-1:0]      redirect_cnt_o
);

    pipe_ctrl_state_e  state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  stall_cnt_q, redirect_cnt_q;
    logic              mem_err_q;
    logic              load_use_c;
    pipe_ctrl_s        run_ctrl, ctrl;

    pipe_hazard_detect u_hazard (
        .rs1_addr     (id_rs1_addr_i),
        .rs2_addr     (id_rs2_addr_i),
        .rs1_used     (id_rs1_used_i),
        .rs2_used     (id_rs2_used_i),
        .ex_rmem_en   (ex_rmem_en_i),
        .ex_wreg_addr (ex_wreg_addr_i),
        .load_use_c   (load_use_c)
    );

    // Branch/load-use decode, shared by RUN and the MEM_WAIT ack cycle.
    // A taken branch squashes the hazarding ID instruction, so it wins.
    always_comb begin
        run_ctrl = '0;
        if (ex_branch_taken_i) begin
            run_ctrl.pc_redirect = 1'b1;
            run_ctrl.if_id_flush = 1'b1;
            run_ctrl.id_ex_flush = 1'b1;
        end else if (load_use_c) begin
            run_ctrl.pc_stall    = 1'b1;
            run_ctrl.if_id_stall = 1'b1;
            run_ctrl.id_ex_flush = 1'b1;
        end
    end

    // Next-state and control decode.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        ctrl    = '0;
        case (state_q)
            PC_RUN: begin
                if (mem_req_i && !mem_ack_i) begin
                    ctrl    = ctrl_hold();
                    state_d = PC_MEM_WAIT;
                    // The request cycle itself is the first unacked cycle.
                    wait_d  = WAIT_W'(1);
                end else begin
                    ctrl = run_ctrl;
                end
            end
            PC_MEM_WAIT: begin
                if (mem_ack_i) begin
                    ctrl    = run_ctrl;
                    state_d = PC_RUN;
                    wait_d  = '0;
                end else begin
                    ctrl = ctrl_hold();
                    if (wait_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
                        state_d = PC_ERROR;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end
            end
            PC_ERROR: begin
                // Frozen until reset; keep bubbling MEM/WB so nothing retires.
                ctrl = ctrl_hold();
            end
            default: begin
                state_d = PC_RUN;
                wait_d  = '0;
            end
        endcase
        // Outputs are forced low for the whole reset interval.
        if (!rst_n) begin
            ctrl = '0;
        end
    end

    // State, wait counter, error flag and performance counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= PC_RUN;
            wait_q         <= '0;
            mem_err_q      <= 1'b0;
            stall_cnt_q    <= '0;
            redirect_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            mem_err_q <= (state_d == PC_ERROR);
            if (ctrl.pc_stall) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (ctrl.pc_redirect) begin
                redirect_cnt_q <= redirect_cnt_q + CNT_W'(1);
            end
        end
    end

    assign pc_stall_o         = ctrl.pc_stall;
    assign if_id_stall_o      = ctrl.if_id_stall;
    assign id_ex_stall_o      = ctrl.id_ex_stall;
    assign ex_mem_stall_o     = ctrl.ex_mem_stall;
    assign if_id_flush_o      = ctrl.if_id_flush;
    assign id_ex_flush_o      = ctrl.id_ex_flush;
    assign mem_wb_flush_o     = ctrl.mem_wb_flush;
    assign pc_redirect_o      = ctrl.pc_redirect;
    assign pc_redirect_addr_o = ctrl.pc_redirect ? ex_branch_target_i : '0;
    assign mem_err_o          = mem_err_q;
    assign stall_cnt_o        = stall_cnt_q;
    assign redirect_cnt_o     = redirect_cnt_q;

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencer for the five-stage Buceros core. It generates the stall, flush and PC-redirect controls for the pipeline registers around `id`. It resolves three events: load-use hazards detected against ID operands, taken branches and jumps resolved in EX, and multi-cycle data-memory accesses in MEM (with a timeout). It also keeps stall and redirect performance counters.

## Interface
- `MEM_TIMEOUT`, default 16: maximum number of MEM_WAIT cycles before an access is declared failed; legal range 2..255.
- `clk  in  1`: core clock; all state updates on the rising edge.
- `rst_n  in  1`: reset, asynchronous assertion, active-low.
- `id_rs1_addr_i`, `id_rs2_addr_i  in  RegAddrBus`: source registers of the instruction in ID.
- `id_rs1_used_i`, `id_rs2_used_i  in  1`: the instruction in ID reads the corresponding source register.
- `ex_rmem_en_i  in  1`: the instruction in EX is a load.
- `ex_wreg_addr_i  in  RegAddrBus`: destination register of the instruction in EX.
- `ex_branch_taken_i  in  1`: branch or jump in EX is taken.
- `ex_branch_target_i  in  RegDataBus`: redirect target.
- `mem_req_i  in  1`: MEM stage is issuing a data-memory access.
- `mem_ack_i  in  1`: data memory completes the access this cycle.
- `pc_stall_o`, `if_id_stall_o`, `id_ex_stall_o`, `ex_mem_stall_o  out  1`: hold the corresponding register.
- `if_id_flush_o`, `id_ex_flush_o`, `mem_wb_flush_o  out  1`: load a bubble (NOP, `wreg_en=0`, `wmem_en=0`) into the register.
- `pc_redirect_o  out  1`, `pc_redirect_addr_o  out  RegDataBus`: load the PC from the target.
- `mem_err_o  out  1`: sticky memory-timeout error.
- `stall_cnt_o  out  32`: number of cycles with `pc_stall_o=1`.
- `redirect_cnt_o  out  32`: number of cycles with `pc_redirect_o=1`.

## Operation
- FSM states: RUN, MEM_WAIT, ERROR. Reset state is RUN.
- **Load-use hazard.** The hazard condition is `ex_rmem_en_i && ex_wreg_addr_i!=0` and (`rs1_used && rs1==ex_wreg_addr` or `rs2_used && rs2==ex_wreg_addr`).
- **Priority in RUN, highest first:**
  1. Memory wait: `mem_req_i && !mem_ack_i`.
     - Assert all four stalls and `mem_wb_flush_o`.
     - Suppress redirect and load-use outputs.
     - Next state is MEM_WAIT.
  2. Taken branch: `ex_branch_taken_i`.
     - Assert `pc_redirect_o`, with `pc_redirect_addr_o=ex_branch_target_i`.
     - Assert `if_id_flush_o` and `id_ex_flush_o`.
     - Load-use is ignored because the hazarding instruction is being squashed.
  3. Load-use: assert `pc_stall_o`, `if_id_stall_o` and `id_ex_flush_o`. This inserts one bubble, after which MEM-to-EX forwarding resolves the dependency.
  4. None of the above: all controls 0.
- **MEM_WAIT.**
  - All four stalls and `mem_wb_flush_o` stay asserted; redirect is suppressed.
  - The wait counter increments every cycle.
  - On `mem_ack_i`: that cycle releases all stalls, and the RUN priority rules 2–4 are evaluated on the current inputs. Next state is RUN and the wait counter is cleared.
  - When the wait counter reaches `MEM_TIMEOUT-1` without an ack: next state is ERROR.
- **ERROR.**
  - `mem_err_o=1`, all stalls are 1, redirect is 0.
  - The block stays in ERROR until reset.
- **Output decode.** All stall, flush and redirect outputs are combinational from the state and current inputs.
- **Counters.** Counters and `mem_err_o` are registered. Both counters wrap modulo 2^32.
- **Reset.** While `rst_n=0`, every output is 0, both counters are 0 and the state is RUN. Reset asserted mid-MEM_WAIT or in ERROR returns the block to RUN immediately.

## Timing
- Stall, flush and redirect outputs have zero latency: they act on the current-cycle inputs, and the pipeline registers sample them on the next edge.
- A load-use stall lasts exactly 1 cycle, because the load advances to MEM on the next edge.
- A branch redirect costs 2 bubbles (the IF/ID and ID/EX contents).
- A memory wait of N cycles (ack in cycle N of the access) stalls the pipeline for exactly N-1 cycles. Ack in the same cycle as the request gives 0 stall cycles.
- A branch held in EX during MEM_WAIT remains asserted because EX is frozen. It redirects in the ack cycle.
- `mem_err_o` rises on the edge after the `MEM_TIMEOUT`-th unacknowledged cycle.

## Structure
- Add to `buceros_header.v`: the state encodings `PC_RUN`, `PC_MEM_WAIT`, `PC_ERROR` and the `PipeCtrlStateBus` width macro.
- Sub-module `pipe_hazard_detect`: purely combinational load-use comparator. It is reused by the forwarding unit.
- The FSM, wait counter and performance counters stay in `pipe_ctrl`.

## Test plan
- Load `x5` in EX, ID uses `rs1=x5` -> one cycle with `pc_stall_o=if_id_stall_o=id_ex_flush_o=1`, `stall_cnt_o=1`. Repeat with `x0` -> no stall.
- `ex_branch_taken_i=1`, target `0x0000_0100` -> `pc_redirect_o=1`, `addr=0x100`, `if_id_flush_o=id_ex_flush_o=1` for one cycle, `redirect_cnt_o=1`.
- Branch taken and load-use in the same cycle -> redirect and flushes only, `pc_stall_o=0`.
- `mem_req_i` with ack on the 4th cycle -> 3 cycles of all stalls plus `mem_wb_flush_o`, release in the ack cycle, `stall_cnt_o=3`. A pending taken branch redirects in the ack cycle.
- `mem_req_i` with no ack, `MEM_TIMEOUT=16` -> `mem_err_o=1` after 16 cycles, stalls held; then assert `rst_n=0` -> all outputs 0, counters 0, state RUN.
